// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between ALU and load writeback,
// and tracks registers that still have a load outstanding.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_dst,
  input  logic [31:0]      alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_dst,
  input  logic [31:0]      mem_data,
  input  logic             ld_issue_valid,
  output logic             ld_issue_ready,
  input  logic [4:0]       ld_dst,
  input  logic [4:0]       rs_q,
  input  logic [4:0]       rt_q,
  output logic             rs_busy,
  output logic             rt_busy,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  // Handshake: a transfer happens in any cycle where valid && ready. Ready is
  // combinational and may depend on valid; requesters hold dst/data stable
  // while valid is high and ready is low. No ready is raised while rst is high.

  typedef enum logic {
    PRIO_MEM = 1'b0,
    PRIO_ALU = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic             alu_win;
  logic             mem_win;
  logic             ld_accept;

  assign cnt_inc = starve_cnt + CNT_W'(1);

  always_comb begin
    alu_win = 1'b0;
    mem_win = 1'b0;
    if (!rst) begin
      if (state == PRIO_ALU) begin
        alu_win = alu_valid;
        mem_win = mem_valid && !alu_valid;
      end else begin
        mem_win = mem_valid;
        alu_win = alu_valid && !mem_valid;
      end
    end
  end

  assign alu_ready = alu_win;
  assign mem_ready = mem_win;

  // A load retiring into the same register this cycle frees it for a new issue.
  assign ld_issue_ready = !rst && ((ld_dst == 5'd0) || !busy[ld_dst] ||
                                   (mem_win && (mem_dst == ld_dst)));
  assign ld_accept = ld_issue_valid && ld_issue_ready;

  assign rs_busy = busy[rs_q];
  assign rt_busy = busy[rt_q];

  always_comb begin
    busy_next = busy;
    if (mem_win) busy_next[mem_dst] = 1'b0;
    if (ld_accept && (ld_dst != 5'd0)) busy_next[ld_dst] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIO_MEM;
      starve_cnt <= '0;
      busy       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      busy  <= busy_next;
      wr_en <= (alu_win && (alu_dst != 5'd0)) || (mem_win && (mem_dst != 5'd0));
      if (alu_win) begin
        wr_addr <= alu_dst;
        wr_data <= alu_data;
      end else if (mem_win) begin
        wr_addr <= mem_dst;
        wr_data <= mem_data;
      end
      case (state)
        PRIO_MEM: begin
          if (alu_valid && mem_valid) begin
            starve_cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(STARVE_LIMIT)) state <= PRIO_ALU;
          end else begin
            starve_cnt <= '0;
          end
        end
        default: begin
          starve_cnt <= '0;
          state      <= PRIO_MEM;
        end
      endcase
    end
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule
